// File: rtl/seq_pkg.sv
// Shared definitions for the serial sequence detector path: serializer FSM encodings
// and detector state constants used by both serializer and detector benches.
package seq_pkg;

    typedef enum logic {
        SER_IDLE  = 1'b0,
        SER_SHIFT = 1'b1
    } ser_state_e;

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2
    } det_state_e;

endpackage

// File: rtl/seq_shift_reg.sv
// Loadable W-bit shift register with a serial-out tap; shifts toward the output end
// (MSB when MSB_FIRST != 0, otherwise LSB) and fills with 0.
module seq_shift_reg #(
    parameter int W         = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [W-1:0] din_i,
    output logic         sout_o
);

    logic [W-1:0] sreg_q;
    logic [W-1:0] sreg_d;

    // Next-state: parallel load wins over shift so a back-to-back reload is exact.
    always_comb begin
        sreg_d = sreg_q;
        if (load_i) begin
            sreg_d = din_i;
        end else if (shift_i) begin
            if (MSB_FIRST != 0) begin
                sreg_d = {sreg_q[W-2:0], 1'b0};
            end else begin
                sreg_d = {1'b0, sreg_q[W-1:1]};
            end
        end else begin
            sreg_d = sreg_q;
        end
    end

    // Shift register storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            sreg_q <= {W{1'b0}};
        end else begin
            sreg_q <= sreg_d;
        end
    end

    assign sout_o = (MSB_FIRST != 0) ? sreg_q[W-1] : sreg_q[0];

endmodule

// File: rtl/seq_serializer.sv
// Parallel-to-serial front end for the sequence detector; valid/ready word intake.
// Optional trailing even-parity bit when SER_PARITY_EN is defined.
module seq_serializer
    import seq_pkg::*;
#(
    parameter int W         = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] din,
    input  logic         din_valid,
    output logic         din_ready,
    output logic         x,
    output logic         x_valid,
    output logic         frame_done
);

`ifdef SER_PARITY_EN
    localparam int FLEN = W + 1;
`else
    localparam int FLEN = W;
`endif
    localparam int CW = $clog2(W + 2);
    localparam logic [CW-1:0] CNT_LOAD = CW'(FLEN - 1);

    ser_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          load_s;
    logic          shift_s;
    logic          accept_s;
    logic          last_s;
    logic          tap_s;
    logic          bit_s;

    assign last_s    = (state_q == SER_SHIFT) && (cnt_q == {CW{1'b0}});
    assign din_ready = (state_q == SER_IDLE) || last_s;
    assign accept_s  = din_valid && din_ready;

    // Next-state, counter and shift-register control.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load_s  = 1'b0;
        shift_s = 1'b0;
        case (state_q)
            SER_IDLE: begin
                if (accept_s) begin
                    state_d = SER_SHIFT;
                    cnt_d   = CNT_LOAD;
                    load_s  = 1'b1;
                end else begin
                    state_d = SER_IDLE;
                end
            end
            SER_SHIFT: begin
                if (cnt_q != {CW{1'b0}}) begin
                    cnt_d   = cnt_q - CW'(1);
                    shift_s = 1'b1;
                end else if (accept_s) begin
                    cnt_d   = CNT_LOAD;
                    load_s  = 1'b1;
                end else begin
                    state_d = SER_IDLE;
                end
            end
            default: begin
                state_d = SER_IDLE;
                cnt_d   = {CW{1'b0}};
            end
        endcase
    end

    // FSM state and bit counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SER_IDLE;
            cnt_q   <= {CW{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    seq_shift_reg #(
        .W         (W),
        .MSB_FIRST (MSB_FIRST)
    ) u_sreg (
        .clk     (clk),
        .reset   (reset),
        .load_i  (load_s),
        .shift_i (shift_s),
        .din_i   (din),
        .sout_o  (tap_s)
    );

`ifdef SER_PARITY_EN
    logic par_q;

    // Even parity of the accepted word, sent after the data bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            par_q <= 1'b0;
        end else if (load_s) begin
            par_q <= ^din;
        end else begin
            par_q <= par_q;
        end
    end

    assign bit_s = (cnt_q == {CW{1'b0}}) ? par_q : tap_s;
`else
    assign bit_s = tap_s;
`endif

    // Idle drives 0 so the detector never samples a stray 1.
    assign x          = (state_q == SER_SHIFT) ? bit_s : 1'b0;
    assign x_valid    = (state_q == SER_SHIFT);
    assign frame_done = last_s;

endmodule

// File: tb/tb_seq_serializer.sv
// Self-checking bench for seq_serializer: one MSB-first and one LSB-first instance,
// a queue-based bit-stream reference model, a vector table and corner sequences.
module tb_seq_serializer;

    localparam int W = 8;
`ifdef SER_PARITY_EN
    localparam int FLEN = W + 1;
`else
    localparam int FLEN = W;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         din_valid;
    logic [W-1:0] din;
    logic         rdy_m, x_m, xv_m, fd_m;
    logic         rdy_l, x_l, xv_l, fd_l;

    int total = 0;
    int bad   = 0;

    bit qm[$];
    bit ql[$];

    typedef struct {
        logic         v;
        logic [W-1:0] d;
        logic         ex;
        logic         exv;
        logic         efd;
        logic         erdy;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    seq_serializer #(.W(W), .MSB_FIRST(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (rdy_m),
        .x          (x_m),
        .x_valid    (xv_m),
        .frame_done (fd_m)
    );

    seq_serializer #(.W(W), .MSB_FIRST(0)) dut_lsb (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (rdy_l),
        .x          (x_l),
        .x_valid    (xv_l),
        .frame_done (fd_l)
    );

    task automatic chk(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: actual=%0b required=%0b", name, $time, act, exp);
        end
    endtask

    // Model: each DUT is a FIFO of pending bits; the head is on x this cycle.
    task automatic model_edge(input logic r, input logic v, input logic [W-1:0] d);
        bit acc;
        acc = v && (qm.size() <= 1);
        if (r) begin
            qm.delete();
            ql.delete();
        end else begin
            if (qm.size() > 0) void'(qm.pop_front());
            if (ql.size() > 0) void'(ql.pop_front());
            if (acc) begin
                for (int i = 0; i < W; i++) begin
                    qm.push_back(d[W-1-i]);
                    ql.push_back(d[i]);
                end
`ifdef SER_PARITY_EN
                qm.push_back(^d);
                ql.push_back(^d);
`endif
            end
        end
    endtask

    task automatic check_model();
        chk("msb_x",     x_m,   (qm.size() > 0) ? qm[0] : 1'b0);
        chk("msb_valid", xv_m,  qm.size() > 0);
        chk("msb_done",  fd_m,  qm.size() == 1);
        chk("msb_ready", rdy_m, qm.size() <= 1);
        chk("lsb_x",     x_l,   (ql.size() > 0) ? ql[0] : 1'b0);
        chk("lsb_valid", xv_l,  ql.size() > 0);
        chk("lsb_done",  fd_l,  ql.size() == 1);
        chk("lsb_ready", rdy_l, ql.size() <= 1);
    endtask

    task automatic tick(input logic r, input logic v, input logic [W-1:0] d);
        reset     = r;
        din_valid = v;
        din       = d;
        @(posedge clk);
        model_edge(r, v, d);
        @(negedge clk);
        check_model();
    endtask

    initial begin
        logic [W-1:0] a5;
        logic [W-1:0] cur;
        logic         pend;
        logic         r;
        logic         acc;
        bit           bits[$];
        vec_t         e;
        int           nvalid;

        reset = 1'b1;
        din_valid = 1'b0;
        din = '0;
        @(negedge clk);

        // Reset state
        tick(1'b1, 1'b1, 8'hFF);
        chk("reset_x", x_m, 1'b0);
        chk("reset_valid", xv_m, 1'b0);
        chk("reset_done", fd_m, 1'b0);
        chk("reset_ready", rdy_m, 1'b1);
        tick(1'b0, 1'b0, 8'h00);

        // Vector table: single A5 frame, MSB first
        a5 = 8'hA5;
        for (int k = 0; k < W; k++) bits.push_back(a5[W-1-k]);
`ifdef SER_PARITY_EN
        bits.push_back(^a5);
`endif
        for (int k = 0; k < FLEN; k++) begin
            e.v    = (k == 0);
            e.d    = (k == 0) ? a5 : 8'h00;
            e.ex   = bits[k];
            e.exv  = 1'b1;
            e.efd  = (k == FLEN - 1);
            e.erdy = (k == FLEN - 1);
            tbl.push_back(e);
        end
        e.v = 1'b0; e.d = 8'h00; e.ex = 1'b0; e.exv = 1'b0; e.efd = 1'b0; e.erdy = 1'b1;
        tbl.push_back(e);
        foreach (tbl[i]) begin
            tick(1'b0, tbl[i].v, tbl[i].d);
            chk("tbl_x",     x_m,   tbl[i].ex);
            chk("tbl_valid", xv_m,  tbl[i].exv);
            chk("tbl_done",  fd_m,  tbl[i].efd);
            chk("tbl_ready", rdy_m, tbl[i].erdy);
        end

        // Back-to-back A5 then 5A: no idle cycle between frames
        nvalid = 0;
        tick(1'b0, 1'b1, 8'hA5);
        if (xv_m) nvalid++;
        for (int i = 0; i < FLEN; i++) begin
            tick(1'b0, 1'b1, 8'h5A);
            if (xv_m) nvalid++;
        end
        for (int i = 0; i < FLEN - 1; i++) begin
            tick(1'b0, 1'b0, 8'h00);
            if (xv_m) nvalid++;
        end
        chk("b2b_all_valid", nvalid == 2 * FLEN, 1'b1);
        tick(1'b0, 1'b0, 8'h00);
        chk("b2b_end_idle", xv_m, 1'b0);

        // LSB first, din=01: 1 then zeros
        tick(1'b0, 1'b1, 8'h01);
        chk("lsb01_first", x_l, 1'b1);
        for (int i = 1; i < W; i++) begin
            tick(1'b0, 1'b0, 8'h00);
            chk("lsb01_zero", x_l, 1'b0);
        end
        for (int i = W; i < FLEN + 1; i++) tick(1'b0, 1'b0, 8'h00);

        // Reset after 3rd bit of FF, then a clean frame
        tick(1'b0, 1'b1, 8'hFF);
        tick(1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b0, 8'h00);
        chk("rst_mid_bit3", x_m, 1'b1);
        tick(1'b1, 1'b0, 8'h00);
        chk("rst_mid_x", x_m, 1'b0);
        chk("rst_mid_valid", xv_m, 1'b0);
        chk("rst_mid_ready", rdy_m, 1'b1);
        chk("rst_mid_done", fd_m, 1'b0);
        tick(1'b0, 1'b1, 8'h3C);
        for (int i = 0; i < FLEN + 1; i++) tick(1'b0, 1'b0, 8'h00);

        // Idle: x stays 0 whatever is on din
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 1'b0, W'($urandom));
            chk("idle_x", x_m | x_l, 1'b0);
            chk("idle_valid", xv_m | xv_l, 1'b0);
        end

`ifdef SER_PARITY_EN
        // Parity bit: 07 -> 1, 03 -> 0
        tick(1'b0, 1'b1, 8'h07);
        for (int i = 1; i < FLEN; i++) tick(1'b0, 1'b0, 8'h00);
        chk("par07_bit", x_m, 1'b1);
        chk("par07_done", fd_m, 1'b1);
        tick(1'b0, 1'b1, 8'h03);
        for (int i = 1; i < FLEN; i++) tick(1'b0, 1'b0, 8'h00);
        chk("par03_bit", x_m, 1'b0);
        chk("par03_done", fd_m, 1'b1);
        tick(1'b0, 1'b0, 8'h00);
`endif

        // Random producer honouring hold-until-ready, occasional reset
        pend = 1'b0;
        cur  = '0;
        for (int c = 0; c < 800; c++) begin
            if (!pend && ($urandom_range(0, 3) != 0)) begin
                cur  = W'($urandom);
                pend = 1'b1;
            end
            r   = ($urandom_range(0, 63) == 0);
            acc = pend && !r && (qm.size() <= 1);
            tick(r, pend, cur);
            if (acc) pend = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
